// File: rtl/i2c_bit_ctrl.sv
// rtl/i2c_bit_ctrl.sv - I2C bit-level controller; `define I2C_CLK_STRETCH_EN lets a slave stretch PH_B via scl_i
module i2c_bit_ctrl #(
  parameter int DIV_W = 8
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic [DIV_W-1:0] clk_div,
  input  logic [2:0]       cmd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             wr_bit,
  output logic             rd_bit,
  output logic             done,
  output logic             busy,
  output logic             arb_lost,
  output logic             scl_oe,
  output logic             sda_oe,
  input  logic             scl_i,
  input  logic             sda_i
);

  localparam logic [2:0] CMD_START = 3'b001;
  localparam logic [2:0] CMD_STOP  = 3'b010;
  localparam logic [2:0] CMD_WRITE = 3'b011;
  localparam logic [2:0] CMD_READ  = 3'b100;

  typedef enum logic [2:0] {IDLE, PH_A, PH_B, PH_C, PH_D} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_cmd;
  logic             r_wr_bit;
  logic             r_scl_oe;
  logic             r_sda_oe;
  logic             r_busy;
  logic             r_done;
  logic             r_arb_lost;
  logic             r_rd_bit;

  state_t           w_state_nxt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [2:0]       w_cmd;
  logic             w_wr;
  logic             w_accept;
  logic             w_is_op;
  logic             w_hold;
  logic             w_last;
  logic             w_scl_nxt;
  logic             w_sda_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_arb_nxt;
  logic             w_rd_nxt;

  assign w_accept = (r_state == IDLE) && cmd_valid;
  assign w_is_op  = (cmd >= CMD_START) && (cmd <= CMD_READ);
  // Output decode must see the incoming command on the acceptance cycle itself
  assign w_cmd    = w_accept ? cmd : r_cmd;
  assign w_wr     = w_accept ? wr_bit : r_wr_bit;

`ifdef I2C_CLK_STRETCH_EN
  assign w_hold = (r_state == PH_B) && !scl_i;
`else
  logic w_unused_scl;
  assign w_unused_scl = scl_i;
  assign w_hold       = 1'b0;
`endif

  assign w_last = (r_cnt == r_div) && !w_hold;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_arb_nxt   = 1'b0;
    w_rd_nxt    = r_rd_bit;
    if (r_state != IDLE) begin
      if (w_last)
        w_cnt_nxt = '0;
      else if (!w_hold)
        w_cnt_nxt = r_cnt + 1'b1;
    end
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_op) begin
            w_state_nxt = PH_A;
            w_cnt_nxt   = '0;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      PH_A: if (w_last) w_state_nxt = PH_B;
      PH_B: if (w_last) w_state_nxt = PH_C;
      PH_C: begin
        if (w_last) begin
          if (r_cmd == CMD_READ)
            w_rd_nxt = sda_i;
          // Released SDA seen low while SCL is high: another master owns the bus
          if ((r_cmd == CMD_WRITE) && r_wr_bit && !sda_i) begin
            w_state_nxt = IDLE;
            w_arb_nxt   = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_state_nxt = PH_D;
          end
        end
      end
      PH_D: begin
        if (w_last) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
          if (r_cmd == CMD_START)
            w_busy_nxt = 1'b1;
          else if (r_cmd == CMD_STOP)
            w_busy_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_scl_nxt = r_scl_oe;
    w_sda_nxt = r_sda_oe;
    if (w_arb_nxt) begin
      w_scl_nxt = 1'b0;
      w_sda_nxt = 1'b0;
    end else if (w_state_nxt != IDLE) begin
      case (w_cmd)
        CMD_START: begin
          // PH_A keeps SCL as-is so a repeated START does not glitch it
          if (w_state_nxt != PH_A)
            w_scl_nxt = (w_state_nxt == PH_D);
          w_sda_nxt = (w_state_nxt == PH_C) || (w_state_nxt == PH_D);
        end
        CMD_STOP: begin
          w_scl_nxt = (w_state_nxt == PH_A);
          w_sda_nxt = (w_state_nxt == PH_A) || (w_state_nxt == PH_B);
        end
        CMD_WRITE: begin
          w_scl_nxt = (w_state_nxt == PH_A) || (w_state_nxt == PH_D);
          w_sda_nxt = ~w_wr;
        end
        CMD_READ: begin
          w_scl_nxt = (w_state_nxt == PH_A) || (w_state_nxt == PH_D);
          w_sda_nxt = 1'b0;
        end
        default: begin
          w_scl_nxt = r_scl_oe;
          w_sda_nxt = r_sda_oe;
        end
      endcase
    end
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_div      <= '0;
      r_cmd      <= 3'b000;
      r_wr_bit   <= 1'b0;
      r_scl_oe   <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_arb_lost <= 1'b0;
      r_rd_bit   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_scl_oe   <= w_scl_nxt;
      r_sda_oe   <= w_sda_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_arb_lost <= w_arb_nxt;
      r_rd_bit   <= w_rd_nxt;
      if (w_accept) begin
        r_cmd    <= cmd;
        r_wr_bit <= wr_bit;
        r_div    <= clk_div;
      end
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign rd_bit    = r_rd_bit;
  assign done      = r_done;
  assign busy      = r_busy;
  assign arb_lost  = r_arb_lost;
  assign scl_oe    = r_scl_oe;
  assign sda_oe    = r_sda_oe;

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// tb/tb_i2c_bit_ctrl.sv - scoreboard bench for i2c_bit_ctrl against a phase-table reference model
module tb_i2c_bit_ctrl;
  localparam int DIV_W      = 8;
  localparam int WAIT_LIMIT = 2000;
`ifdef I2C_CLK_STRETCH_EN
  localparam int STRETCH_CYC = 10;
`else
  localparam int STRETCH_CYC = 0;
`endif

  logic             mclk = 1'b0;
  logic             rst = 1'b0;
  logic [DIV_W-1:0] clk_div = '0;
  logic [2:0]       cmd = 3'b000;
  logic             cmd_valid = 1'b0;
  logic             wr_bit = 1'b0;
  logic             scl_i = 1'b1;
  logic             sda_i = 1'b1;
  logic             cmd_ready, rd_bit, done, busy, arb_lost, scl_oe, sda_oe;

  always #5 mclk = ~mclk;

  i2c_bit_ctrl #(.DIV_W(DIV_W)) dut (
    .mclk(mclk), .rst(rst), .clk_div(clk_div), .cmd(cmd), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .wr_bit(wr_bit), .rd_bit(rd_bit), .done(done), .busy(busy),
    .arb_lost(arb_lost), .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_i(scl_i), .sda_i(sda_i)
  );

  typedef struct {int cyc; bit scl; bit sda;} bus_t;
  typedef struct {int cyc; bit arb; bit busy; bit rd;} res_t;

  bus_t bus_q[$];
  res_t res_q[$];
  bus_t cur_b;
  res_t cur_r;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_acc = 0;
  int   st_start = 0;
  bit   st_en = 1'b0;
  bit   hold_scl = 1'b0, hold_sda = 1'b0;
  bit   m_scl = 1'b0, m_sda = 1'b0, m_busy = 1'b0, m_rd = 1'b0;

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_arb_lost", arb_lost, 0);
    check("rst_rd_bit", rd_bit, 0);
    check("rst_cmd_ready", cmd_ready, 1);
  endtask

  // Reference: each command is four phases of (clk_div+1) cycles with fixed SCL/SDA patterns
  task automatic model_cmd(input logic [2:0] c, input bit w, input int d, input bit sdav,
                           input bit st, input int acc);
    int t = acc + 1;
    int len;
    bit s = 1'b0, a = 1'b0;
    if (c < 3'd1 || c > 3'd4) begin
      res_q.push_back('{acc + 1, 1'b0, m_busy, m_rd});
      return;
    end
    for (int p = 0; p < 4; p++) begin
      if (c == 3'd3 && w && !sdav && p == 3) begin
        bus_q.push_back('{t, 1'b0, 1'b0});
        res_q.push_back('{t, 1'b1, 1'b0, m_rd});
        m_scl = 1'b0; m_sda = 1'b0; m_busy = 1'b0;
        return;
      end
      case (c)
        3'd1: begin s = (p == 0) ? m_scl : (p == 3); a = (p >= 2); end
        3'd2: begin s = (p == 0); a = (p <= 1); end
        3'd3: begin s = (p == 0 || p == 3); a = !w; end
        default: begin s = (p == 0 || p == 3); a = 1'b0; end
      endcase
      len = (p == 1) ? d + 1 + (st ? STRETCH_CYC : 0) : d + 1;
      for (int k = 0; k < len; k++) begin
        bus_q.push_back('{t, s, a});
        t++;
      end
    end
    m_scl = s; m_sda = a;
    if (c == 3'd1) m_busy = 1'b1;
    if (c == 3'd2) m_busy = 1'b0;
    if (c == 3'd4) m_rd = sdav;
    res_q.push_back('{t, 1'b0, m_busy, m_rd});
  endtask

  task automatic issue(input logic [2:0] c, input bit w, input int d, input bit sdav, input bit st);
    int guard = 0;
    @(negedge mclk);
    cmd = c; wr_bit = w; clk_div = d[DIV_W-1:0]; cmd_valid = 1'b1;
    while (!cmd_ready && guard < WAIT_LIMIT) begin
      @(negedge mclk);
      guard++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    sda_i = sdav;
    last_acc = cyc;
    if (st) begin
      st_en = 1'b1;
      st_start = cyc + d + 2;
    end
    model_cmd(c, w, d, sdav, st, cyc);
  endtask

  initial forever begin
    @(negedge mclk);
    scl_i = !(st_en && cyc >= st_start && cyc < st_start + 10);
  end

  initial forever begin
    @(negedge mclk);
    if (rst) begin
      while (bus_q.size() > 0 && bus_q[0].cyc <= cyc) begin
        cur_b = bus_q.pop_front();
        hold_scl = cur_b.scl;
        hold_sda = cur_b.sda;
      end
      check("scl_oe", scl_oe, hold_scl);
      check("sda_oe", sda_oe, hold_sda);
      if (done || arb_lost) begin
        if (res_q.size() == 0) begin
          check("unexpected_completion", {done, arb_lost}, 0);
        end else begin
          cur_r = res_q.pop_front();
          check("completion_cycle", cyc, cur_r.cyc);
          check("done", done, !cur_r.arb);
          check("arb_lost", arb_lost, cur_r.arb);
          check("busy", busy, cur_r.busy);
          check("rd_bit", rd_bit, cur_r.rd);
          check("cmd_ready", cmd_ready, 1);
        end
      end else if (res_q.size() > 0 && res_q[0].cyc < cyc) begin
        cur_r = res_q.pop_front();
        check("missing_completion", cyc, cur_r.cyc);
      end
    end
  end

  initial begin
    int guard;
    int acc;
    rst = 1'b0;
    repeat (3) @(negedge mclk);
    check_reset_vals();
    #3 rst = 1'b1;

    issue(3'd1, 0, 3, 1, 0);
    issue(3'd3, 0, 0, 1, 0);
    issue(3'd2, 0, 0, 1, 0);
    issue(3'd4, 0, 1, 1, 0);
    issue(3'd4, 0, 1, 0, 0);
    issue(3'd1, 0, 1, 1, 0);
    issue(3'd3, 1, 1, 0, 0);
    issue(3'd0, 0, 0, 1, 0);
    issue(3'd7, 1, 4, 0, 0);
    issue(3'd1, 0, 0, 1, 0);
    issue(3'd3, 0, 2, 1, 1);
    issue(3'd3, 1, 0, 1, 0);

    issue(3'd3, 0, 2, 1, 0);
    acc = last_acc;
    while (cyc < acc + 8) @(negedge mclk);
    cmd_valid = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset_vals();
    bus_q.delete();
    res_q.delete();
    hold_scl = 1'b0; hold_sda = 1'b0;
    m_scl = 1'b0; m_sda = 1'b0; m_busy = 1'b0; m_rd = 1'b0;
    st_en = 1'b0;
    @(negedge mclk);
    #3 rst = 1'b1;
    issue(3'd1, 0, 2, 1, 0);

    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 5),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end
    @(negedge mclk);
    cmd_valid = 1'b0;

    guard = 0;
    while ((res_q.size() > 0 || bus_q.size() > 0) && guard < WAIT_LIMIT) begin
      @(negedge mclk);
      guard++;
    end
    check("drain_pending", res_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
